// File: rtl/dot_ctrl.sv
// Dot-product sequencer: clears an external MAC, streams operand pairs into it, waits out the
// MAC pipeline and captures the accumulated result. Optional stall counter: DOT_CTRL_STALL_CNT_EN.
module dot_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    a_reset_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic [DATA_WIDTH-1:0]   mac_op_a,
  output logic [DATA_WIDTH-1:0]   mac_op_b,
  output logic                    mac_clr,
  input  logic [2*DATA_WIDTH-1:0] mac_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    busy
`ifdef DOT_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  // Two cycles of MAC latency plus one settle cycle before the accumulator is sampled.
  localparam int unsigned DrainCycles = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic [1:0]              drain_cnt_q, drain_cnt_d;
  logic [DATA_WIDTH-1:0]   mac_op_a_q, mac_op_a_d;
  logic [DATA_WIDTH-1:0]   mac_op_b_q, mac_op_b_d;
  logic                    mac_clr_q, mac_clr_d;
  logic                    out_valid_q, out_valid_d;
  logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic in_feed;
  logic last_hs;
  logic drain_done;

  assign in_feed    = (state_q == StFeed);
  assign cnt_inc    = cnt_q + LEN_WIDTH'(1);
  assign last_hs    = in_feed & in_valid & (cnt_inc == len_q);
  assign drain_done = (drain_cnt_q == 2'(DrainCycles - 1));

  // State register
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len != '0) ? StClear : StDone;
        end
      end
      StClear: state_d = StFeed;
      StFeed: begin
        if (last_hs) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath next-state
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b1;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_cnt_d = drain_cnt_q;
    out_data_d  = out_data_q;
    mac_op_a_d  = '0;
    mac_op_b_d  = '0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          len_d = len;
          cnt_d = '0;
          if (len == '0) begin
            out_data_d = '0;
          end
        end
      end
      StFeed: begin
        in_ready    = 1'b1;
        drain_cnt_d = '0;
        if (in_valid) begin
          cnt_d      = cnt_inc;
          mac_op_a_d = in_a;
          mac_op_b_d = in_b;
        end
      end
      StDrain: begin
        if (drain_done) begin
          drain_cnt_d = '0;
          out_data_d  = mac_result;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Registered from the next state so they line up exactly with CLEAR / DONE.
  assign mac_clr_d   = (state_d == StClear);
  assign out_valid_d = (state_d == StDone);

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      drain_cnt_q <= '0;
      mac_op_a_q  <= '0;
      mac_op_b_q  <= '0;
      mac_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mac_op_a_q  <= mac_op_a_d;
      mac_op_b_q  <= mac_op_b_d;
      mac_clr_q   <= mac_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign mac_op_a  = mac_op_a_q;
  assign mac_op_b  = mac_op_b_q;
  assign mac_clr   = mac_clr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DOT_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StIdle) && start) begin
      stall_cnt_d = '0;
    end else if (in_feed && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dot_ctrl.sv
// Bench for dot_ctrl: behavioural 2-stage MAC, vector table, directed corner sequences and
// randomized transactions checked against a sum-of-products model.
module tb_dot_ctrl;

  localparam int DW = 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            a_reset_n;
  logic            start;
  logic [LW-1:0]   len;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic [DW-1:0]   mac_op_a, mac_op_b;
  logic            mac_clr;
  logic [2*DW-1:0] mac_result;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic            busy;
`ifdef DOT_CTRL_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  dot_ctrl #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_op_a  (mac_op_a),
    .mac_op_b  (mac_op_b),
    .mac_clr   (mac_clr),
    .mac_result(mac_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef DOT_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // MAC: product register then accumulator, asynchronously cleared by mac_clr.
  logic [2*DW-1:0] prod_q, acc_q;
  always_ff @(posedge clk or posedge mac_clr) begin
    if (mac_clr) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= 16'(mac_op_a) * 16'(mac_op_b);
      acc_q  <= acc_q + prod_q;
    end
  end
  assign mac_result = acc_q;

  int clr_pulses = 0;
  int clr_hi     = 0;
  always @(posedge mac_clr) clr_pulses++;
  always @(negedge clk) if (mac_clr) clr_hi++;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] va [16];
  logic [7:0] vb [16];
  int         vgap [16];
  int         exp_stall;

  typedef struct packed {
    logic [7:0]  len;
    logic [7:0]  gap;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int l);
    int unsigned s = 0;
    for (int i = 0; i < l; i++) s += int'(va[i]) * int'(vb[i]);
    return 16'(s & 32'hFFFF);
  endfunction

  // All tasks are entered and left on a falling edge.
  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap,
                           output bit ok);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic feed_txn(input string name, input int l);
    bit ok;
    do_start(l[7:0]);
`ifdef DOT_CTRL_STALL_CNT_EN
    check({name, "_stall_clr"}, 32'(stall_cnt), 0);
`endif
    exp_stall = 0;
    for (int i = 0; i < l; i++) begin
      send_pair(va[i], vb[i], (i == 0) ? 0 : vgap[i], ok);
      if (i != 0) exp_stall += vgap[i];
      check($sformatf("%s_hs%0d", name, i), 32'(ok), 1);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (out_valid) lat = k;
      else @(negedge clk);
    end
  endtask

  task automatic consume(input string name, input logic [15:0] exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_clr"}, 32'(out_valid), 0);
    check({name, "_busy_clr"}, 32'(busy), 0);
    check({name, "_data_hold"}, 32'(out_data), 32'(exp));
  endtask

  // out_valid rises on the 3rd edge after the last handshake edge (4th cycle after the
  // handshake cycle).
  task automatic finish_txn(input string name, input logic [15:0] exp, input int c0_p,
                            input int c0_h, input int hold);
    int lat;
    wait_out(lat);
    check({name, "_lat"}, 32'(lat), 3);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    check({name, "_clr_pulses"}, 32'(clr_pulses - c0_p), 1);
    check({name, "_clr_cycles"}, 32'(clr_hi - c0_h), 1);
`ifdef DOT_CTRL_STALL_CNT_EN
    check({name, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d", name, k), {15'd0, out_valid, out_data}, {16'd1, exp});
    end
    consume(name, exp);
  endtask

  task automatic run_txn(input string name, input int l, input logic [15:0] exp);
    int c0_p, c0_h;
    c0_p = clr_pulses;
    c0_h = clr_hi;
    feed_txn(name, l);
    finish_txn(name, exp, c0_p, c0_h, int'($urandom_range(0, 2)));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0_p, c0_h, l, bad;
    bit ok;

    tbl[0] = '{len: 8'd3, gap: 8'd0, a: 32'h00060402, b: 32'h00070503, exp: 16'h0044};
    tbl[1] = '{len: 8'd3, gap: 8'd2, a: 32'h00060402, b: 32'h00070503, exp: 16'h0044};
    tbl[2] = '{len: 8'd2, gap: 8'd0, a: 32'h0000FFFF, b: 32'h0000FFFF, exp: 16'hFC02};
    tbl[3] = '{len: 8'd1, gap: 8'd1, a: 32'h000000FF, b: 32'h000000FF, exp: 16'hFE01};
    tbl[4] = '{len: 8'd4, gap: 8'd1, a: 32'h04030201, b: 32'h281E140A, exp: 16'h012C};
    tbl[5] = '{len: 8'd4, gap: 8'd0, a: 32'h11FF8000, b: 32'h03010263, exp: 16'h0232};

    a_reset_n = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mac_ops", {16'd0, mac_op_a, mac_op_b}, 0);
    a_reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      l = int'(tbl[i].len);
      for (int j = 0; j < l; j++) begin
        va[j]   = tbl[i].a[8*j +: 8];
        vb[j]   = tbl[i].b[8*j +: 8];
        vgap[j] = int'(tbl[i].gap);
      end
      run_txn($sformatf("tbl%0d", i), l, tbl[i].exp);
    end

    // Zero length: straight to DONE with out_data cleared, no MAC clear, no input acceptance.
    c0_p = clr_pulses;
    bad  = 0;
    start = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_valid", 32'(out_valid), 1);
    check("zero_data", 32'(out_data), 0);
    check("zero_in_ready", 32'(in_ready), 0);
    check("zero_busy", 32'(busy), 1);
    check("zero_no_clr", 32'(clr_pulses - c0_p), 0);
    consume("zero", 16'h0000);

    // Back-pressure in DONE with a start pulse that must be ignored.
    va[0] = 8'd9; vb[0] = 8'd9; va[1] = 8'd10; vb[1] = 8'd3; vgap[1] = 0;
    c0_p = clr_pulses;
    c0_h = clr_hi;
    feed_txn("bp", 2);
    wait_out(l);
    check("bp_lat", 32'(l), 3);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1;
        len   = 8'd2;
      end
      @(negedge clk);
      start = 1'b0;
      check($sformatf("bp_hold%0d", k), {15'd0, out_valid, out_data}, {16'd1, 16'd111});
    end
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_clr_once", 32'(clr_pulses - c0_p), 1);
    consume("bp", 16'd111);
    check("bp_idle_after", 32'(clr_pulses - c0_p), 1);

    // Reset after the first of three handshakes abandons the operation.
    va[0] = 8'd2; vb[0] = 8'd3;
    do_start(8'd3);
    send_pair(va[0], vb[0], 0, ok);
    check("rmid_hs", 32'(ok), 1);
    a_reset_n = 1'b0;
    #1;
    check("rmid_ops", {16'd0, mac_op_a, mac_op_b}, 0);
    check("rmid_clr", 32'(mac_clr), 0);
    check("rmid_valid", 32'(out_valid), 0);
    check("rmid_data", 32'(out_data), 0);
    check("rmid_in_ready", 32'(in_ready), 0);
    check("rmid_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    a_reset_n = 1'b1;
    @(negedge clk);
    va[0] = 8'd255; vb[0] = 8'd255;
    run_txn("rmid_after", 1, 16'hFE01);

    // Randomized transactions against the sum-of-products model.
    for (int t = 0; t < 15; t++) begin
      l = int'($urandom_range(1, 8));
      for (int j = 0; j < l; j++) begin
        va[j]   = 8'($urandom);
        vb[j]   = 8'($urandom);
        vgap[j] = int'($urandom_range(0, 2));
      end
      run_txn($sformatf("rnd%0d", t), l, model(l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dot_ctrl.md
DOT_CTRL -- requirements
Module: dot_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: operand width; the result is 2*DATA_WIDTH bits.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 8: width of the vector-length field.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- a_reset_n  in  1  asynchronous active-low reset
- start  in  1  request a new dot product
- len  in  LEN_WIDTH  number of operand pairs; sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid is also high
- in_a, in_b  in  DATA_WIDTH  operand pair
- mac_op_a, mac_op_b  out  DATA_WIDTH  operands to the downstream MAC; registered
- mac_clr  out  1  registered clear; drives the MAC asynchronous active-high reset
- mac_result  in  2*DATA_WIDTH  MAC accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid is also high
- out_data  out  2*DATA_WIDTH  captured dot product
- busy  out  1  high in every state except IDLE

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-006 In IDLE, start with len!=0 SHALL latch len and go to CLEAR.
REQ-007 In IDLE, start with len==0 SHALL set out_data=0 and go to DONE with no mac_clr pulse.
REQ-008 start SHALL be ignored in every state except IDLE.
REQ-009 CLEAR SHALL last exactly one cycle with mac_clr=1, then go to FEED; mac_clr SHALL be 0 in every other state.
REQ-010 in_ready SHALL equal 1 only in FEED; a handshake is in_valid & in_ready at a rising edge.
REQ-011 Each handshake SHALL load mac_op_a/mac_op_b with in_a/in_b for exactly one cycle; in every other cycle they SHALL be 0, so the MAC accumulates 0.
REQ-012 FEED SHALL count handshakes; the handshake that makes count==len SHALL move the FSM to DRAIN at that edge.
REQ-013 DRAIN SHALL last exactly 3 cycles, covering 2 cycles of MAC latency plus 1 settle cycle.
REQ-014 The edge that leaves DRAIN SHALL capture mac_result into out_data and go to DONE.
REQ-015 In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready=1; the FSM SHALL then go to IDLE and clear out_valid on the same edge.
REQ-016 out_data SHALL hold its value after DONE until the next capture.
REQ-017 Overflow SHALL wrap modulo 2^(2*DATA_WIDTH), as in the MAC; the block SHALL add no saturation.
REQ-018 Gaps (in_valid=0 in FEED) SHALL stall without limit and SHALL not alter the result.

Reset
REQ-019 a_reset_n=0 SHALL asynchronously force state=IDLE and clear all of the following: counters, mac_op_a, mac_op_b, mac_clr, out_valid, out_data and in_ready (all 0).
REQ-020 A reset in any state, including mid-FEED or mid-DRAIN, SHALL abandon the operation; the MAC is cleared by the next CLEAR.

Configuration
REQ-021 With DOT_CTRL_STALL_CNT_EN defined, the block SHALL add output stall_cnt[15:0]:
- counts FEED cycles with in_valid=0
- saturates at 0xFFFF
- cleared on accepted start and on reset
REQ-022 Without DOT_CTRL_STALL_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Directed scenario, back-to-back pairs: len=3, pairs (2,3),(4,5),(6,7), MAC attached -> exactly one mac_clr pulse; out_data=0x0044, out_valid 4 cycles after the last handshake.
REQ-024 Directed scenario, gaps: same vector with in_valid=0 for 2 cycles between pairs -> out_data=0x0044; stall_cnt=4 when the macro is defined.
REQ-025 Directed scenario, zero length: start with len=0 -> out_valid=1 and out_data=0x0000 one cycle later; mac_clr and in_ready stay 0.
REQ-026 Directed scenario, output back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; a start pulse during DONE is ignored.
REQ-027 Directed scenario, reset mid-operation: a_reset_n=0 after 1 of 3 handshakes -> all outputs 0 and busy=0. Then len=1 with pair (255,255) -> out_data=0xFE01.
REQ-028 Directed scenario, wrap-around: len=2 with pairs (255,255),(255,255) -> out_data=0xFC02.
